// File: rtl/aes128_iter_engine.sv
// aes128_iter_engine: iterative AES-128 encryptor with built-in round control.
// UNROLL rounds per clock; optional abort input enabled by AES128_ITER_ABORT_EN.
module aes128_iter_engine #(
    parameter int UNROLL = 1,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
`ifdef AES128_ITER_ABORT_EN
    input  logic             abort,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     plain_text,
    input  logic [127:0]     cipher_key,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     cipher_text,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5 && UNROLL != 10) begin : g_bad_unroll
        $error("aes128_iter_engine: UNROLL must be 1, 2, 5 or 10");
    end

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // SubBytes followed by ShiftRows; state is column-major, byte 0 at the MSB
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        int src;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            src = (i % 4) + 4 * (((i / 4) + (i % 4)) % 4);
            o[127-8*i -: 8] = sbox(s[127-8*src -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_cols(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return o;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] t, w0, w1, w2, w3;
        t  = {sbox(k[23:16]), sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])} ^ {rc, 24'h0};
        w0 = k[127:96] ^ t;
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    state_t           r_fsm;
    logic [127:0]     r_state;
    logic [127:0]     r_key;
    logic [TAG_W-1:0] r_tag;
    logic [3:0]       r_rnd;
    logic [127:0]     r_ct;
    logic [TAG_W-1:0] r_otag;

    logic [127:0] w_st  [UNROLL+1];
    logic [127:0] w_key [UNROLL+1];
    logic         w_last;
    logic         w_abort;
    logic         w_accept;

`ifdef AES128_ITER_ABORT_EN
    assign w_abort = abort & (r_fsm != IDLE);
`else
    assign w_abort = 1'b0;
`endif

    assign in_ready    = ~rst & ((r_fsm == IDLE) | ((r_fsm == DONE) & out_ready));
    assign w_accept    = in_valid & in_ready & ~w_abort;
    assign out_valid   = (r_fsm == DONE);
    assign busy        = (r_fsm == ROUND);
    assign cipher_text = r_ct;
    assign out_tag     = r_otag;

    assign w_st[0]  = r_state;
    assign w_key[0] = r_key;
    assign w_last   = (r_rnd + 4'(UNROLL - 1)) == 4'd10;

    // Combinational chain of UNROLL rounds starting at round r_rnd
    for (genvar i = 0; i < UNROLL; i++) begin : g_round
        logic [3:0]   w_rn;
        logic [127:0] w_sr;
        logic [127:0] w_mc;
        assign w_rn       = r_rnd + 4'(i);
        assign w_key[i+1] = next_key(w_key[i], rcon(w_rn));
        assign w_sr       = sub_shift(w_st[i]);
        assign w_mc       = (w_rn == 4'd10) ? w_sr : mix_cols(w_sr);
        assign w_st[i+1]  = w_mc ^ w_key[i+1];
    end

    // Round controller: load on accept, iterate, hold result until handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm   <= IDLE;
            r_state <= '0;
            r_key   <= '0;
            r_tag   <= '0;
            r_rnd   <= '0;
            r_ct    <= '0;
            r_otag  <= '0;
        end else if (w_abort) begin
            r_fsm <= IDLE;
            r_rnd <= '0;
        end else if (w_accept) begin
            r_fsm   <= ROUND;
            r_state <= plain_text ^ cipher_key;
            r_key   <= cipher_key;
            r_tag   <= in_tag;
            r_rnd   <= 4'd1;
        end else begin
            unique case (r_fsm)
                ROUND: begin
                    r_state <= w_st[UNROLL];
                    r_key   <= w_key[UNROLL];
                    if (w_last) begin
                        r_fsm  <= DONE;
                        r_ct   <= w_st[UNROLL];
                        r_otag <= r_tag;
                        r_rnd  <= '0;
                    end else begin
                        r_rnd <= r_rnd + 4'(UNROLL);
                    end
                end
                DONE: begin
                    if (out_ready) r_fsm <= IDLE;
                end
                default: r_fsm <= r_fsm;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_iter_engine.sv
// tb_aes128_iter_engine: scoreboard bench for aes128_iter_engine.
// Four instances (UNROLL 1,2,5,10) share stimulus; a negedge monitor checks results.
`timescale 1ns/1ps
module tb_aes128_iter_engine;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        int           d;
        logic [127:0] ct;
        logic [3:0]   tag;
        int           acc;
        int           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] pt, key;
    logic [3:0]   itag;
    logic         ordy;
    logic         abort;
    logic [3:0]   ivld, irdy, ovld, bsy;
    logic [127:0] ct   [4];
    logic [3:0]   otag [4];

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   lat_tab [4] = '{10, 5, 2, 1};
    exp_t sb [$];
    exp_t e;
    logic [3:0] seen = 4'b0;
    int   hs_edge [4] = '{0, 0, 0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        aes128_iter_engine #(
            .UNROLL(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 5 : 10),
            .TAG_W(4)
        ) u_dut (
            .clk(clk),
            .rst(rst),
`ifdef AES128_ITER_ABORT_EN
            .abort(g == 0 ? abort : 1'b0),
`endif
            .in_valid(ivld[g]),
            .in_ready(irdy[g]),
            .plain_text(pt),
            .cipher_key(key),
            .in_tag(itag),
            .out_valid(ovld[g]),
            .out_ready(ordy),
            .cipher_text(ct[g]),
            .out_tag(otag[g]),
            .busy(bsy[g])
        );
    end

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    // Monitor: compare every presented result against the scoreboard head
    always @(negedge clk) begin
        for (int g = 0; g < 4; g++) begin
            if (!ovld[g]) begin
                seen[g] = 1'b0;
            end else if (sb.size() == 0 || sb[0].d != g) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out dut%0d: out_valid=1, required no result", g);
            end else begin
                e = sb[0];
                if (!seen[g]) begin
                    seen[g] = 1'b1;
                    chk("latency", 128'(cyc - e.acc), 128'(e.lat));
                end
                chk("cipher_text", ct[g], e.ct);
                chk("out_tag", 128'(otag[g]), 128'(e.tag));
                if (ordy) begin
                    void'(sb.pop_front());
                    seen[g] = 1'b0;
                    hs_edge[g] = cyc + 1;
                end else begin
                    chk("in_ready_stall", 128'(irdy[g]), 128'(0));
                end
            end
        end
    end

    // Present a block on instance d; returns with in_valid still high
    task automatic send(input int d, input logic [127:0] p, input logic [127:0] k,
                        input logic [3:0] t, input logic [127:0] x, output int acc);
        exp_t en;
        int n;
        pt = p;
        key = k;
        itag = t;
        ivld = 4'b0;
        ivld[d] = 1'b1;
        acc = -1;
        n = 0;
        while (acc < 0 && n < 40) begin
            @(negedge clk);
            if (irdy[d]) begin
                acc = cyc + 1;
                en.d = d;
                en.ct = x;
                en.tag = t;
                en.acc = acc;
                en.lat = lat_tab[d];
                sb.push_back(en);
            end
            n++;
        end
        if (acc < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL accept_timeout dut%0d: in_ready=0, required 1", d);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        while (sb.size() != 0 && n < lim) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        @(posedge clk);
        #2;
    endtask

    task automatic wait_valid(input int lim);
        int n;
        n = 0;
        while (!ovld[0] && n < lim) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk("wait_out_valid", 128'(ovld[0]), 128'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int a, a1, a2;
        rst = 1'b1;
        ordy = 1'b1;
        ivld = 4'b0;
        pt = '0;
        key = '0;
        itag = '0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_in_ready", 128'(irdy), 128'(0));
        chk("rst_out_valid", 128'(ovld), 128'(0));
        chk("rst_busy", 128'(bsy), 128'(0));
        chk("rst_cipher_text", ct[0], 128'(0));
        chk("rst_out_tag", 128'(otag[3]), 128'(0));
        rst = 1'b0;
        #1;
        chk("idle_in_ready", 128'(irdy), 128'hf);
        @(posedge clk);
        #2;

        send(0, PT_B, KEY_B, 4'h5, CT_B, a);
        ivld = 4'b0;
        drain(30);

        for (int d = 1; d < 4; d++) begin
            send(d, PT_C, KEY_C, 4'(d), CT_C, a);
            ivld = 4'b0;
            drain(30);
        end

        ordy = 1'b0;
        send(0, PT_C, KEY_C, 4'ha, CT_C, a);
        ivld = 4'b0;
        wait_valid(20);
        repeat (6) @(posedge clk);
        #2;
        ordy = 1'b1;
        @(posedge clk);
        #2;
        chk("bp_valid_drop", 128'(ovld[0]), 128'(0));
        chk("bp_ct_retained", ct[0], CT_C);
        chk("bp_one_handshake", 128'(sb.size()), 128'(0));

        send(0, PT_B, KEY_B, 4'h1, CT_B, a1);
        send(0, PT_C, KEY_C, 4'h2, CT_C, a2);
        ivld = 4'b0;
        chk("b2b_accept_on_hs", 128'(a2), 128'(hs_edge[0]));
        chk("b2b_spacing", 128'(a2 - a1), 128'(11));
        drain(30);

        send(0, PT_C, KEY_C, 4'h7, CT_C, a);
        ivld = 4'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("mid_busy", 128'(bsy[0]), 128'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_ct", ct[0], 128'(0));
        chk("mid_rst_tag", 128'(otag[0]), 128'(0));
        chk("mid_rst_valid", 128'(ovld[0]), 128'(0));
        chk("mid_rst_busy", 128'(bsy[0]), 128'(0));
        chk("mid_rst_ready", 128'(irdy[0]), 128'(0));
        sb.delete();
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 128'(irdy[0]), 128'(1));
        @(posedge clk);
        #2;
        send(0, PT_C, KEY_C, 4'h3, CT_C, a);
        ivld = 4'b0;
        drain(30);

`ifdef AES128_ITER_ABORT_EN
        send(0, PT_B, KEY_B, 4'h9, CT_B, a);
        repeat (5) @(posedge clk);
        #2;
        abort = 1'b1;
        @(posedge clk);
        #2;
        abort = 1'b0;
        ivld = 4'b0;
        chk("abort_busy", 128'(bsy[0]), 128'(0));
        chk("abort_valid", 128'(ovld[0]), 128'(0));
        chk("abort_idle_ready", 128'(irdy[0]), 128'(1));
        sb.delete();
        repeat (12) @(posedge clk);
        #2;

        ordy = 1'b0;
        send(0, PT_C, KEY_C, 4'h6, CT_C, a);
        wait_valid(20);
        ordy = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #2;
        abort = 1'b0;
        ivld = 4'b0;
        chk("abort_done_busy", 128'(bsy[0]), 128'(0));
        chk("abort_done_valid", 128'(ovld[0]), 128'(0));
        chk("abort_done_ct", ct[0], CT_C);
        sb.delete();
        @(posedge clk);
        #2;

        send(0, PT_B, KEY_B, 4'hc, CT_B, a);
        ivld = 4'b0;
        drain(30);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
